// File: rtl/synth_pkg.sv
// Shared synth-chain definitions: ADSR state encoding, envelope level range and
// the audio sample width used by square_amp, adsr_envelope and i2s_controller.
package synth_pkg;

    localparam int unsigned ADSR_LEVEL_W = 15;
    localparam logic [ADSR_LEVEL_W-1:0] ADSR_MAX_LEVEL = 15'd32767;
    localparam int unsigned SAMPLE_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } adsr_state_t;

endpackage

// File: rtl/adsr_envelope.sv
// ADSR envelope stage: scales the 1-bit oscillator value into a signed sample
// whose magnitude follows an attack/decay/sustain/release envelope keyed by gate.
// Ports:
//   clk          system clock
//   reset        synchronous, active-low reset
//   sample_tick  one-clk pulse at sample rate, advances the envelope level
//   gate         note on (1) / off (0)
//   in           oscillator value, 1 = positive half, 0 = negative half
//   sample       signed 16-bit sample, one clk behind level/in
//   active       high whenever the envelope is not idle
module adsr_envelope
    import synth_pkg::*;
#(
    parameter logic [ADSR_LEVEL_W-1:0] ATTACK_STEP   = 15'd8192,
    parameter logic [ADSR_LEVEL_W-1:0] DECAY_STEP    = 15'd4096,
    parameter logic [ADSR_LEVEL_W-1:0] SUSTAIN_LEVEL = 15'd16384,
    parameter logic [ADSR_LEVEL_W-1:0] RELEASE_STEP  = 15'd2048
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_tick,
    input  logic                       gate,
    input  logic                       in,
    output logic signed [SAMPLE_W-1:0] sample,
    output logic                       active
);

    adsr_state_t             state_q;
    adsr_state_t             state_d;
    logic [ADSR_LEVEL_W-1:0] level_q;
    logic [ADSR_LEVEL_W-1:0] level_d;
    logic                    gate_q;

    logic                    rise;
    logic                    fall;
    logic [SAMPLE_W-1:0]     attack_sum;
    logic [SAMPLE_W-1:0]     decay_diff;
    logic [SAMPLE_W-1:0]     release_diff;
    logic [ADSR_LEVEL_W-1:0] attack_level;
    logic [ADSR_LEVEL_W-1:0] decay_level;
    logic [ADSR_LEVEL_W-1:0] release_level;

    assign rise = gate & ~gate_q;
    assign fall = ~gate & gate_q;

    // Saturating level arithmetic, carried one bit wider than the level.
    assign attack_sum   = {1'b0, level_q} + {1'b0, ATTACK_STEP};
    assign decay_diff   = {1'b0, level_q} - {1'b0, DECAY_STEP};
    assign release_diff = {1'b0, level_q} - {1'b0, RELEASE_STEP};

    assign attack_level  = (attack_sum > {1'b0, ADSR_MAX_LEVEL}) ? ADSR_MAX_LEVEL
                                                                  : attack_sum[ADSR_LEVEL_W-1:0];
    // Borrow out of bit 15 means the subtraction underflowed.
    assign decay_level   = (decay_diff[SAMPLE_W-1] || (decay_diff[ADSR_LEVEL_W-1:0] < SUSTAIN_LEVEL))
                           ? SUSTAIN_LEVEL : decay_diff[ADSR_LEVEL_W-1:0];
    assign release_level = release_diff[SAMPLE_W-1] ? '0 : release_diff[ADSR_LEVEL_W-1:0];

    // Level update uses the current state; gate events then override the next state.
    always_comb begin
        level_d = level_q;
        state_d = state_q;

        if (sample_tick) begin
            case (state_q)
                ATTACK:  level_d = attack_level;
                DECAY:   level_d = decay_level;
                SUSTAIN: level_d = SUSTAIN_LEVEL;
                RELEASE: level_d = release_level;
                default: level_d = level_q;
            endcase
        end

        if (rise) begin
            state_d = ATTACK;
        end else if (fall && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
            state_d = RELEASE;
        end else if (!fall && sample_tick) begin
            case (state_q)
                ATTACK:  if (level_d == ADSR_MAX_LEVEL) state_d = DECAY;
                DECAY:   if (level_d == SUSTAIN_LEVEL)  state_d = SUSTAIN;
                RELEASE: if (level_d == '0)             state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // State, level and output registers; sample follows level/in one clk later.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            level_q <= '0;
            gate_q  <= 1'b0;
            sample  <= '0;
            active  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            gate_q  <= gate;
            sample  <= in ? SAMPLE_W'({1'b0, level_q}) : SAMPLE_W'(-{1'b0, level_q});
            active  <= (state_d != IDLE);
        end
    end

    // Zero steps would stall the envelope in ATTACK, DECAY or RELEASE forever.
    always_ff @(posedge clk) begin
        assert (ATTACK_STEP  != '0) else $error("ATTACK_STEP must be >= 1");
        assert (DECAY_STEP   != '0) else $error("DECAY_STEP must be >= 1");
        assert (RELEASE_STEP != '0) else $error("RELEASE_STEP must be >= 1");
    end

endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
- Envelope stage between square_wave_gen and i2s_controller; replaces the fixed-amplitude square_amp.
- Shapes the 1-bit oscillator value into a signed 16-bit sample whose magnitude follows an attack/decay/sustain/release envelope keyed by a gate.
- Envelope advances once per sample_tick. Output holds one sample per tick for i2s_controller sample_left/sample_right.

Parameters:
- ATTACK_STEP, 15'd8192: level increment per tick in ATTACK; must be >= 1.
- DECAY_STEP, 15'd4096: level decrement per tick in DECAY; must be >= 1.
- SUSTAIN_LEVEL, 15'd16384: hold level in SUSTAIN; range 0..32767.
- RELEASE_STEP, 15'd2048: level decrement per tick in RELEASE; must be >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- sample_tick  input  1  one-clk pulse at sample rate; envelope level update enable
- gate  input  1  note on (1) / off (0); may toggle on any cycle
- in  input  1  square_wave_gen value; 1 = positive half, 0 = negative half
- sample  output  16  signed two's-complement sample to i2s_controller
- active  output  1  high whenever state != IDLE

Behaviour:
- Reset (reset==0 at posedge clk): state=IDLE, level=0, gate_q=0, sample=16'h0000, active=0. Reset overrides all other inputs, including mid-envelope.
- level: 15-bit unsigned, 0..32767 (MAX_LEVEL). Arithmetic is done 16 bits wide, then saturated.
- gate_q: registered gate. rise = gate & ~gate_q; fall = ~gate & gate_q.
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- Level update, only on cycles with sample_tick=1. Uses the state held at the start of the cycle:
  - IDLE: level unchanged (stays 0).
  - ATTACK: level = min(level+ATTACK_STEP, 32767).
  - DECAY: level = max(level-DECAY_STEP, SUSTAIN_LEVEL).
  - SUSTAIN: level = SUSTAIN_LEVEL.
  - RELEASE: level = max(level-RELEASE_STEP, 0), no unsigned wrap.
- State transitions are evaluated every cycle, in priority order:
  - 1. rise (any state) -> ATTACK. Level is NOT cleared; retrigger continues from the current level.
  - 2. fall in ATTACK/DECAY/SUSTAIN -> RELEASE.
  - 3. Tick-driven, only if there is no gate event:
    - ATTACK -> DECAY when the updated level == 32767.
    - DECAY -> SUSTAIN when the updated level == SUSTAIN_LEVEL.
    - RELEASE -> IDLE when the updated level == 0.
- Simultaneous gate event and tick: the level update uses the old state's rule; the gate event sets the next state.
- Gate held high across reset: after reset deasserts, gate_q=0, so rise fires and ATTACK starts on the first cycle.
- SUSTAIN_LEVEL=32767: DECAY exits to SUSTAIN on its first tick. SUSTAIN_LEVEL=0: SUSTAIN holds silence while active stays 1.
- Output register, updated every cycle, 1-cycle latency from level/in:
  - sample = in ? {1'b0,level} : -{1'b0,level}.
  - level=0 gives 0 for both values of in.
  - Most negative output is -32767 (16'h8001).
- active = (state != IDLE), registered with the state.

Decomposition:
- Shared package synth_pkg holds:
  - adsr_state_t enum (IDLE, ATTACK, DECAY, SUSTAIN, RELEASE), 3 bits.
  - ADSR_LEVEL_W = 15 and ADSR_MAX_LEVEL = 15'd32767.
  - SAMPLE_W = 16, shared with square_amp and i2s_controller.
- No sub-module. Edge detect, FSM, saturating add/sub and sign stage stay flat in one module.
- Parameter range checks (steps >= 1) are simulation-only assertions.

Test Plan:
- Default parameters, sample_tick every 4 clks unless noted.
- Reset: hold reset=0 for 3 clks with gate=1, in=1 -> sample=0, active=0. On release, ATTACK starts next cycle and active=1.
- Attack/decay: gate=1, in=1 -> per-tick level 8192, 16384, 24576, 32767 (saturated, ->DECAY), 28671, 24575, 20479, 16384 (clamped, ->SUSTAIN). sample equals level one clk after each update.
- Polarity: in SUSTAIN, toggle in to 0 -> sample=16'hC000 (-16384) next clk. in back to 1 -> 16'h4000.
- Release: drop gate in SUSTAIN -> RELEASE, levels 14336, 12288, ..., 2048, 0 (8 ticks) -> IDLE. active falls the same clk state reaches IDLE. sample=0 afterwards.
- Retrigger: raise gate in RELEASE at level 8192 -> ATTACK with no drop to 0. Next tick level=16384.
- Simultaneous: gate fall on the same clk as a tick in ATTACK at level 8192 -> level=16384 (attack rule applied), state=RELEASE. Next tick level=14336.
